qos_bus_arbiter: RTL and testbench
==================================

Name: qos_bus_arbiter

Overview:
Two-class (high/low priority) arbiter that owns a shared bus/resource with a full request/hold/release handshake.
- Round-robin within each class; high priority beats low.
- Aging counter prevents low-priority starvation.
- Owner keeps the grant until it signals done, or optionally until a hold timeout.
- Sits between the requesting ports and the shared resource mux; drives its select.

Parameters:
- NUM_PORTS, 4, number of requesters (>=2).
- AGE_LIMIT, 8, consecutive HP-won arbitrations with LP pending before LP is forced (>=1).
- MAX_HOLD, 16, maximum grant duration in cycles when timeout is compiled in (>=2).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- hp_req  in  NUM_PORTS  high-priority request per port.
- lp_req  in  NUM_PORTS  low-priority request per port.
- done  in  NUM_PORTS  owner release strobe.
- grant  out  NUM_PORTS  registered one-hot grant, or all zero.
- grant_valid  out  1  registered, equals OR of grant.
- grant_id  out  $clog2(NUM_PORTS)  registered binary index of owner.
- grant_hp  out  1  registered; 1 if current grant was won in HP class.
- timeout_pulse  out  1  registered one-cycle strobe on forced release.

Behaviour:
- Reset (rst_n low at a clk edge):
  - All outputs 0.
  - FSM -> IDLE; hp_ptr = lp_ptr = 0; age_cnt = 0; hold_cnt = 0.
  - Reset mid-grant drops the grant at that edge, with no timeout_pulse.
- FSM states: IDLE, BUSY.
- IDLE:
  - Effective HP set = hp_req.
  - Effective LP set = lp_req & ~hp_req; a port raising both counts as HP.
  - If any request: winner registered into grant/grant_id/grant_hp at the next edge, FSM -> BUSY. Request-to-grant latency is 1 cycle.
  - If no request: stay IDLE, outputs 0.
- Class select:
  - LP wins if the LP set is nonzero and (HP set is zero or age_cnt == AGE_LIMIT).
  - Otherwise HP wins.
- Round-robin within a class:
  - Scan from the class pointer upward with wrap-around; first set bit wins.
  - On grant, that class pointer becomes (winner+1) mod NUM_PORTS; the other pointer is unchanged.
- age_cnt (per arbitration decision only):
  - +1 when HP wins while the LP set is nonzero.
  - Cleared when LP wins, or when the LP set is zero at decision time.
  - Saturates at AGE_LIMIT.
- BUSY:
  - Grant held stable; requests from any port are ignored, including the owner dropping its request.
  - done[grant_id]=1 -> grant cleared at the next edge, FSM -> IDLE.
  - done from a non-owner is ignored; done in IDLE is ignored.
- Re-arbitration:
  - Always one IDLE cycle between consecutive grants.
  - Back-to-back grant rate is one grant per 2 cycles minimum.
- Invariant: grant is always one-hot or zero, and grant_id is meaningful only when grant_valid=1.

Optional Feature:
Macro: ARB_HOLD_TIMEOUT_EN.
- Defined:
  - hold_cnt counts up from 0 starting with the first BUSY cycle.
  - If hold_cnt == MAX_HOLD-1 without owner done, grant clears at the next edge, FSM -> IDLE, and timeout_pulse=1 for exactly that one cycle.
  - Grant is therefore visible for exactly MAX_HOLD cycles.
  - done and limit in the same cycle count as a normal release; no pulse.
- Undefined:
  - No hold_cnt; grant held until done.
  - timeout_pulse tied to 0.

Decomposition:
- Package arb_pkg holds:
  - state enum typedef (IDLE, BUSY);
  - localparam ID_W = $clog2(NUM_PORTS) helper;
  - counter width constants.
- One sub-module, qos_rr_pick:
  - combinational inputs: req vector, pointer;
  - outputs: one-hot pick, binary index, any flag;
  - instantiated twice, once per class.

Test Plan (NUM_PORTS=4, AGE_LIMIT=2, MAX_HOLD=4):
1. rst_n low 2 cycles with hp_req=1111 -> grant=0000 and all outputs 0 during reset; first edge after release gives grant=0001, grant_id=0, grant_hp=1.
2. hp_req=1111 held, owner pulses done on its first grant cycle -> grants 0001, 0010, 0100, 1000, 0001, each followed by one all-zero IDLE cycle.
3. hp_req=0100, lp_req=0001 -> grant=0100, grant_hp=1; after done, grant=0001, grant_hp=0 (only if hp_req has dropped by then).
4. hp_req=0010 and lp_req=1000 held, done each grant -> grant sequence 0010, 0010, 1000, 0010, 0010, 1000; grant_hp 1,1,0,1,1,0.
5. Grant to port 0, done never asserted:
   - with ARB_HOLD_TIMEOUT_EN: grant=0001 for exactly 4 cycles, timeout_pulse=1 on the cycle grant returns to 0000;
   - without it: grant held 20+ cycles, timeout_pulse stays 0.
6. Grant 0100 active:
   - done=0001 -> ignored, grant unchanged;
   - then rst_n low one cycle -> grant=0000 at that edge, timeout_pulse=0, next arbitration of hp_req=1111 grants 0001 (pointers back to 0).

Source files
------------

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types, defaults and width helpers for the QoS bus arbiter
package arb_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_e;

   localparam int DEF_NUM_PORTS = 4;
   localparam int DEF_AGE_LIMIT = 8;
   localparam int DEF_MAX_HOLD  = 16;

   function automatic int id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Width of a counter that must hold every value 0..limit inclusive.
   function automatic int cnt_w(input int limit);
      return (limit > 1) ? $clog2(limit + 1) : 1;
   endfunction

endpackage

// File: rtl/qos_rr_pick.sv
// rtl/qos_rr_pick.sv - combinational round-robin picker, scans upward from ptr with wrap
module qos_rr_pick #(
   parameter int N    = 4,
   parameter int ID_W = 2
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] ptr,
   output logic [N-1:0]    pick,
   output logic [ID_W-1:0] index,
   output logic            any
);

   logic            found;
   logic [ID_W-1:0] j;

   always_comb begin
      pick  = '0;
      index = '0;
      found = 1'b0;
      j     = '0;
      for (int i = 0; i < N; i++) begin
         j = ID_W'((int'(ptr) + i) % N);
         if (!found && req[j]) begin
            found   = 1'b1;
            pick[j] = 1'b1;
            index   = j;
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/qos_bus_arbiter.sv
// rtl/qos_bus_arbiter.sv - two-class round-robin bus arbiter with LP aging and hold handshake
// Optional forced release after MAX_HOLD cycles: define ARB_HOLD_TIMEOUT_EN.
module qos_bus_arbiter
   import arb_pkg::*;
#(
   parameter int NUM_PORTS = DEF_NUM_PORTS,
   parameter int AGE_LIMIT = DEF_AGE_LIMIT,
   parameter int MAX_HOLD  = DEF_MAX_HOLD
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_PORTS-1:0]         hp_req,
   input  logic [NUM_PORTS-1:0]         lp_req,
   input  logic [NUM_PORTS-1:0]         done,
   output logic [NUM_PORTS-1:0]         grant,
   output logic                         grant_valid,
   output logic [id_w(NUM_PORTS)-1:0]   grant_id,
   output logic                         grant_hp,
   output logic                         timeout_pulse
);

   localparam int ID_W  = id_w(NUM_PORTS);
   localparam int AGE_W = cnt_w(AGE_LIMIT);

   if (NUM_PORTS < 2 || AGE_LIMIT < 1 || MAX_HOLD < 2) begin : g_param_check
      $error("qos_bus_arbiter: illegal parameter set");
   end

   arb_state_e           state_q, state_d;
   logic [NUM_PORTS-1:0] grant_q, grant_d;
   logic [ID_W-1:0]      id_q, id_d;
   logic                 hp_q, hp_d;
   logic [ID_W-1:0]      hp_ptr_q, hp_ptr_d;
   logic [ID_W-1:0]      lp_ptr_q, lp_ptr_d;
   logic [AGE_W-1:0]     age_q, age_d;

   logic [NUM_PORTS-1:0] hp_set, lp_set, hp_pick, lp_pick;
   logic [ID_W-1:0]      hp_idx, lp_idx;
   logic                 hp_any, lp_any, lp_win, age_full;

   // A port raising both classes is treated as high priority only.
   assign hp_set   = hp_req;
   assign lp_set   = lp_req & ~hp_req;
   assign age_full = (age_q == AGE_W'(AGE_LIMIT));
   assign lp_win   = lp_any && (!hp_any || age_full);

   qos_rr_pick #(.N(NUM_PORTS), .ID_W(ID_W)) u_hp_pick (
      .req   (hp_set),
      .ptr   (hp_ptr_q),
      .pick  (hp_pick),
      .index (hp_idx),
      .any   (hp_any)
   );

   qos_rr_pick #(.N(NUM_PORTS), .ID_W(ID_W)) u_lp_pick (
      .req   (lp_set),
      .ptr   (lp_ptr_q),
      .pick  (lp_pick),
      .index (lp_idx),
      .any   (lp_any)
   );

`ifdef ARB_HOLD_TIMEOUT_EN
   localparam int HOLD_W = cnt_w(MAX_HOLD - 1);
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              pulse_q, pulse_d;
`endif

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      id_d     = id_q;
      hp_d     = hp_q;
      hp_ptr_d = hp_ptr_q;
      lp_ptr_d = lp_ptr_q;
      age_d    = age_q;
`ifdef ARB_HOLD_TIMEOUT_EN
      hold_d   = hold_q;
      pulse_d  = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (hp_any || lp_any) begin
               state_d = BUSY;
`ifdef ARB_HOLD_TIMEOUT_EN
               hold_d  = '0;
`endif
               if (lp_win) begin
                  grant_d  = lp_pick;
                  id_d     = lp_idx;
                  hp_d     = 1'b0;
                  lp_ptr_d = ID_W'((int'(lp_idx) + 1) % NUM_PORTS);
                  age_d    = '0;
               end else begin
                  grant_d  = hp_pick;
                  id_d     = hp_idx;
                  hp_d     = 1'b1;
                  hp_ptr_d = ID_W'((int'(hp_idx) + 1) % NUM_PORTS);
                  // Age only while LP is actually being passed over.
                  if (!lp_any)
                     age_d = '0;
                  else if (!age_full)
                     age_d = age_q + AGE_W'(1);
               end
            end
         end
         BUSY: begin
            if (done[id_q]) begin
               state_d = IDLE;
               grant_d = '0;
               id_d    = '0;
               hp_d    = 1'b0;
            end
`ifdef ARB_HOLD_TIMEOUT_EN
            else if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
               state_d = IDLE;
               grant_d = '0;
               id_d    = '0;
               hp_d    = 1'b0;
               pulse_d = 1'b1;
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
`endif
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
            id_d    = '0;
            hp_d    = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         id_q        <= '0;
         hp_q        <= 1'b0;
         hp_ptr_q    <= '0;
         lp_ptr_q    <= '0;
         age_q       <= '0;
         grant_valid <= 1'b0;
`ifdef ARB_HOLD_TIMEOUT_EN
         hold_q      <= '0;
         pulse_q     <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         id_q        <= id_d;
         hp_q        <= hp_d;
         hp_ptr_q    <= hp_ptr_d;
         lp_ptr_q    <= lp_ptr_d;
         age_q       <= age_d;
         grant_valid <= |grant_d;
`ifdef ARB_HOLD_TIMEOUT_EN
         hold_q      <= hold_d;
         pulse_q     <= pulse_d;
`endif
      end
   end

   assign grant    = grant_q;
   assign grant_id = id_q;
   assign grant_hp = hp_q;

`ifdef ARB_HOLD_TIMEOUT_EN
   assign timeout_pulse = pulse_q;
`else
   assign timeout_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_qos_bus_arbiter.sv
// tb/tb_qos_bus_arbiter.sv - self-checking bench: directed plan steps plus random traffic vs reference model
module tb_qos_bus_arbiter;

   localparam int N  = 4;
   localparam int AL = 2;
   localparam int MH = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] hp_req = '0;
   logic [N-1:0] lp_req = '0;
   logic [N-1:0] done = '0;
   logic [N-1:0] grant;
   logic         grant_valid;
   logic [1:0]   grant_id;
   logic         grant_hp;
   logic         timeout_pulse;

   always #5 clk = ~clk;

   qos_bus_arbiter #(.NUM_PORTS(N), .AGE_LIMIT(AL), .MAX_HOLD(MH)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .hp_req        (hp_req),
      .lp_req        (lp_req),
      .done          (done),
      .grant         (grant),
      .grant_valid   (grant_valid),
      .grant_id      (grant_id),
      .grant_hp      (grant_hp),
      .timeout_pulse (timeout_pulse)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: owner index (-1 = none), class pointers, aging and hold counts.
   int m_owner = -1;
   bit m_hp = 1'b0;
   int m_hp_ptr = 0;
   int m_lp_ptr = 0;
   int m_age = 0;
   int m_hold = 0;
   bit m_pulse = 1'b0;

   logic [3:0] t4_grant [6] = '{4'b0010, 4'b0010, 4'b1000, 4'b0010, 4'b0010, 4'b1000};
   logic       t4_hp    [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int rr_first(input logic [N-1:0] set, input int ptr);
      for (int k = 0; k < N; k++)
         if (set[(ptr + k) % N]) return (ptr + k) % N;
      return -1;
   endfunction

   task automatic model_edge();
      logic [N-1:0] hs, ls;
      bit lpw;
      m_pulse = 1'b0;
      if (!rst_n) begin
         m_owner = -1; m_hp = 1'b0; m_hp_ptr = 0; m_lp_ptr = 0; m_age = 0; m_hold = 0;
      end else if (m_owner < 0) begin
         hs = hp_req;
         ls = lp_req & ~hp_req;
         if ((hs | ls) != 0) begin
            lpw = (ls != 0) && (hs == 0 || m_age == AL);
            m_hold = 0;
            if (lpw) begin
               m_owner = rr_first(ls, m_lp_ptr);
               m_lp_ptr = (m_owner + 1) % N;
               m_hp = 1'b0;
               m_age = 0;
            end else begin
               m_owner = rr_first(hs, m_hp_ptr);
               m_hp_ptr = (m_owner + 1) % N;
               m_hp = 1'b1;
               m_age = (ls == 0) ? 0 : ((m_age + 1 > AL) ? AL : m_age + 1);
            end
         end
      end else if (done[m_owner]) begin
         m_owner = -1;
      end else begin
`ifdef ARB_HOLD_TIMEOUT_EN
         if (m_hold == MH - 1) begin
            m_owner = -1;
            m_pulse = 1'b1;
         end else begin
            m_hold++;
         end
`endif
      end
   endtask

   task automatic compare_all();
      logic [N-1:0] eg;
      eg = (m_owner >= 0) ? N'(1 << m_owner) : '0;
      chk("grant", 32'(grant), 32'(eg));
      chk("grant_valid", 32'(grant_valid), 32'(m_owner >= 0));
      chk("grant_hp", 32'(grant_hp), 32'((m_owner >= 0) && m_hp));
      chk("timeout_pulse", 32'(timeout_pulse), 32'(m_pulse));
      chk("onehot", 32'($countones(grant) <= 1), 32'd1);
      if (m_owner >= 0) chk("grant_id", 32'(grant_id), 32'(m_owner));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   initial begin
      // Plan 1: reset with all HP requests, then first grant to port 0.
      rst_n = 1'b0; hp_req = 4'b1111;
      step(); step();
      chk("t1_reset_grant", 32'(grant), 32'd0);
      rst_n = 1'b1;
      step();
      chk("t1_first_grant", 32'(grant), 32'b0001);
      chk("t1_first_hp", 32'(grant_hp), 32'd1);

      // Plan 2: HP round-robin with release on the first grant cycle.
      for (int i = 0; i < 5; i++) begin
         chk("t2_seq", 32'(grant), 32'(1 << (i % 4)));
         done = 4'b1111;
         step();
         chk("t2_idle_gap", 32'(grant), 32'd0);
         done = 4'b0000;
         step();
      end

      // Plan 3: HP beats LP, then LP served once HP drops.
      hp_req = 4'b0000; done = 4'b1111;
      step();
      done = 4'b0000; hp_req = 4'b0100; lp_req = 4'b0001;
      step();
      chk("t3_hp_grant", 32'(grant), 32'b0100);
      done = 4'b1111; hp_req = 4'b0000;
      step();
      done = 4'b0000;
      step();
      chk("t3_lp_grant", 32'(grant), 32'b0001);
      chk("t3_lp_class", 32'(grant_hp), 32'd0);
      done = 4'b1111; lp_req = 4'b0000;
      step();
      done = 4'b0000;
      step();

      // Plan 4: aging forces LP every third arbitration.
      hp_req = 4'b0010; lp_req = 4'b1000;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("t4_grant", 32'(grant), 32'(t4_grant[i]));
         chk("t4_hp", 32'(grant_hp), 32'(t4_hp[i]));
         done = 4'b1111;
         step();
         done = 4'b0000;
      end
      hp_req = 4'b0000; lp_req = 4'b0000;
      step();

      // Plan 5: owner never releases.
      hp_req = 4'b0001;
      step();
      chk("t5_grant", 32'(grant), 32'b0001);
      for (int i = 0; i < 25; i++) step();
      hp_req = 4'b0000; done = 4'b1111;
      step();
      done = 4'b0000;
      step();

      // Plan 6: non-owner done ignored, reset mid-grant, pointers restart.
      hp_req = 4'b0100;
      step();
      chk("t6_grant", 32'(grant), 32'b0100);
      done = 4'b0001;
      step();
      chk("t6_nonowner_done", 32'(grant), 32'b0100);
      done = 4'b0000; hp_req = 4'b0000; rst_n = 1'b0;
      step();
      chk("t6_reset_drop", 32'(grant), 32'd0);
      chk("t6_reset_pulse", 32'(timeout_pulse), 32'd0);
      rst_n = 1'b1; hp_req = 4'b1111;
      step();
      chk("t6_ptr_restart", 32'(grant), 32'b0001);

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         rst_n  = ($urandom_range(0, 59) != 0);
         hp_req = N'($urandom) & N'($urandom);
         lp_req = N'($urandom);
         case ($urandom_range(0, 3))
            0:       done = 4'b1111;
            1:       done = N'($urandom);
            default: done = 4'b0000;
         endcase
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
